// File: rtl/segment_share_scheduler.sv
// Shares one fixed-latency segment datapath between the if/else requesters with round-robin arbitration and tagged returns.
// Optional grant counters (gcnt_0/gcnt_1) are compiled in when SCHED_STATS_EN is defined.
module segment_share_scheduler #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             req_0,
  input  logic [WIDTH-1:0] data_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] data_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             dp_start,
  output logic [WIDTH-1:0] dp_in,
  input  logic [WIDTH-1:0] dp_out,
  output logic [WIDTH-1:0] result,
  output logic             valid_0,
  output logic             valid_1,
  output logic             busy,
`ifdef SCHED_STATS_EN
  output logic [15:0]      gcnt_0,
  output logic [15:0]      gcnt_1,
`endif
  output logic             done
);

  localparam int CW = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_q;
  logic             rr_q;
  logic             dp_start_q;
  logic [WIDTH-1:0] dp_in_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_0_q;
  logic             valid_1_q;
  logic             done_q;
  logic [LATENCY:0] tag_v_q;
  logic [LATENCY:0] tag_id_q;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    inflight_d;
  logic             contested;
  logic             gnt_any;
  logic             ret_any;

  // rr_q names the requester that wins the next contested cycle
  always_comb begin
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    contested = req_0 & req_1;
    if (state_q == RUN) begin
      if (contested) begin
        gnt_0 = ~rr_q;
        gnt_1 = rr_q;
      end else begin
        gnt_0 = req_0;
        gnt_1 = req_1;
      end
    end
  end

  assign gnt_any = gnt_0 | gnt_1;
  assign ret_any = valid_0_q | valid_1_q;

  always_comb begin
    inflight_d = inflight_q;
    if (gnt_any && !ret_any) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!gnt_any && ret_any) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      dp_start_q <= 1'b0;
      dp_in_q    <= '0;
      result_q   <= '0;
      valid_0_q  <= 1'b0;
      valid_1_q  <= 1'b0;
      done_q     <= 1'b0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      inflight_q <= '0;
    end else begin
      dp_start_q <= gnt_any;
      if (gnt_any) begin
        dp_in_q <= gnt_1 ? data_1 : data_0;
      end
      if (state_q == RUN && contested) begin
        rr_q <= ~rr_q;
      end
      // Tag stage LATENCY lines up with dp_out for the op that owns it
      tag_v_q   <= {tag_v_q[LATENCY-1:0], gnt_any};
      tag_id_q  <= {tag_id_q[LATENCY-1:0], gnt_1};
      valid_0_q <= tag_v_q[LATENCY] & ~tag_id_q[LATENCY];
      valid_1_q <= tag_v_q[LATENCY] & tag_id_q[LATENCY];
      if (tag_v_q[LATENCY]) begin
        result_q <= dp_out;
      end
      inflight_q <= inflight_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     if (stop) state_q <= DRAIN;
        DRAIN: begin
          if (inflight_d == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] gcnt_0_q;
  logic [15:0] gcnt_1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt_0_q <= '0;
      gcnt_1_q <= '0;
    end else if (state_q == IDLE && start) begin
      gcnt_0_q <= '0;
      gcnt_1_q <= '0;
    end else begin
      if (gnt_0 && gcnt_0_q != 16'hFFFF) gcnt_0_q <= gcnt_0_q + 16'd1;
      if (gnt_1 && gcnt_1_q != 16'hFFFF) gcnt_1_q <= gcnt_1_q + 16'd1;
    end
  end

  assign gcnt_0 = gcnt_0_q;
  assign gcnt_1 = gcnt_1_q;
`endif

  assign dp_start = dp_start_q;
  assign dp_in    = dp_in_q;
  assign result   = result_q;
  assign valid_0  = valid_0_q;
  assign valid_1  = valid_1_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_segment_share_scheduler.sv
// Bench for segment_share_scheduler: per-cycle reference model with a return scoreboard, table vectors and corner sequences.
module tb_segment_share_scheduler;

  localparam int W   = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stop = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0;
  logic [W-1:0]  data_0 = '0, data_1 = '0;
  logic          gnt_0, gnt_1, dp_start, valid_0, valid_1, busy, done;
  logic [W-1:0]  dp_in, dp_out, result;
`ifdef SCHED_STATS_EN
  logic [15:0]   gcnt_0, gcnt_1;
`endif

  segment_share_scheduler #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .dp_start(dp_start), .dp_in(dp_in),
    .dp_out(dp_out), .result(result), .valid_0(valid_0), .valid_1(valid_1),
    .busy(busy),
`ifdef SCHED_STATS_EN
    .gcnt_0(gcnt_0), .gcnt_1(gcnt_1),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: identity with LAT register stages
  logic [W-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_in;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_out = dp_pipe[LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference model, advanced once per cycle at the falling edge
  typedef struct { int due; bit id; logic [W-1:0] data; } sb_t;
  sb_t     exp_q[$];
  int      cyc = 0;
  int      m_state = 0;  // 0 idle, 1 run, 2 drain
  bit      m_rr = 0, m_done = 0, m_dps = 0;
  logic [W-1:0] m_dpi = '0;

  always @(negedge clk) begin
    bit eg0, eg1;
    sb_t e;
    if (reset) begin
      chk("rst_gnt", {30'd0, gnt_0, gnt_1}, 32'd0);
      chk("rst_dp_start", {31'd0, dp_start}, 32'd0);
      chk("rst_dp_in", dp_in, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_valid", {30'd0, valid_0, valid_1}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      exp_q.delete();
      m_state = 0; m_rr = 0; m_done = 0; m_dps = 0;
    end else begin
      eg0 = 0; eg1 = 0;
      if (m_state == 1) begin
        if (req_0 && req_1) begin eg0 = !m_rr; eg1 = m_rr; end
        else begin eg0 = req_0; eg1 = req_1; end
      end
      chk("gnt_0", {31'd0, gnt_0}, {31'd0, eg0});
      chk("gnt_1", {31'd0, gnt_1}, {31'd0, eg1});
      chk("dp_start", {31'd0, dp_start}, {31'd0, m_dps});
      if (m_dps) chk("dp_in", dp_in, m_dpi);
      chk("busy", {31'd0, busy}, {31'd0, m_state != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("valid_0", {31'd0, valid_0}, {31'd0, !e.id});
        chk("valid_1", {31'd0, valid_1}, {31'd0, e.id});
        chk("result", result, e.data);
      end else begin
        chk("no_valid", {30'd0, valid_0, valid_1}, 32'd0);
      end
      if (eg0 || eg1) exp_q.push_back('{due: cyc + 2 + LAT, id: eg1, data: eg1 ? data_1 : data_0});
      m_dps = eg0 | eg1;
      if (eg0 || eg1) m_dpi = eg1 ? data_1 : data_0;
      if (m_state == 1 && req_0 && req_1) m_rr = !m_rr;
      m_done = 0;
      case (m_state)
        0: if (start) m_state = 1;
        1: if (stop) m_state = 2;
        default: if (exp_q.size() == 0) begin m_state = 0; m_done = 1; end
      endcase
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic start, stop, r0; logic [W-1:0] d0; logic r1; logic [W-1:0] d1; logic eg0, eg1;
  } vec_t;
  vec_t tbl [13];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  initial begin
    int dcnt, vcnt;
    bit prev_done;

    // start, stop, req_0, data_0, req_1, data_1, expected gnt_0, gnt_1
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h55, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h55, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h55, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h55, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, 32'h0,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h31, 1'b1, 32'h32, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 32'h42, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      tick();
      start = tbl[i].start; stop = tbl[i].stop;
      req_0 = tbl[i].r0; data_0 = tbl[i].d0; req_1 = tbl[i].r1; data_1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), {30'd0, gnt_0, gnt_1}, {30'd0, tbl[i].eg0, tbl[i].eg1});
    end
    tick();
    start = 1'b0; stop = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
    repeat (6) @(posedge clk);

    // stop with three ops in flight while req_0 stays asserted
    pulse_start();
    req_0 = 1'b1; data_0 = 32'h1;
    tick(); data_0 = 32'h2;
    tick(); data_0 = 32'h3; stop = 1'b1;
    tick(); stop = 1'b0;
    dcnt = 0; prev_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) chk("drain_no_gnt", {31'd0, gnt_0}, 32'd0);
      if (k == 0) chk("drain_busy", {31'd0, busy}, 32'd1);
      if (prev_done) chk("busy_after_done", {31'd0, busy}, 32'd0);
      prev_done = done;
      if (done) dcnt++;
    end
    chk("done_once", 32'(dcnt), 32'd1);
    tick(); req_0 = 1'b0;

    // asynchronous reset with two ops in flight
    pulse_start();
    req_0 = 1'b1; data_0 = 32'h77;
    tick(); req_0 = 1'b0; req_1 = 1'b1; data_1 = 32'h88;
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("arst_gnt", {30'd0, gnt_0, gnt_1}, 32'd0);
    chk("arst_dp", {31'd0, dp_start}, 32'd0);
    chk("arst_dp_in", dp_in, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_valid", {30'd0, valid_0, valid_1}, 32'd0);
    chk("arst_busy_done", {30'd0, busy, done}, 32'd0);
    req_1 = 1'b0;
    tick(); reset = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_0 || valid_1) vcnt++;
    end
    chk("arst_no_valid", 32'(vcnt), 32'd0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

`ifdef SCHED_STATS_EN
    pulse_start();
    req_0 = 1'b1; data_0 = 32'h5;
    repeat (4) tick();
    tick(); req_0 = 1'b0; req_1 = 1'b1; data_1 = 32'h6;
    repeat (2) tick();
    tick(); req_1 = 1'b0; stop = 1'b1;
    tick(); stop = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("gcnt_0", {16'd0, gcnt_0}, 32'd5);
    chk("gcnt_1", {16'd0, gcnt_1}, 32'd3);
    pulse_start();
    @(negedge clk);
    chk("gcnt_clr", {gcnt_0, gcnt_1}, 32'd0);
    tick(); stop = 1'b1;
    tick(); stop = 1'b0;
    repeat (4) @(posedge clk);
`endif

    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
